// File: rtl/proc_defs.sv
// Shared definitions for the 4-bit processor control path: opcodes, ALU
// encodings, writeback source codes and sequencer state encodings.
package proc_defs;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_MOV  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_NOT  = 4'h7;
    localparam logic [3:0] OP_LDI  = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_JZ   = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] ALU_ADD    = 3'b000;
    localparam logic [2:0] ALU_SUB    = 3'b001;
    localparam logic [2:0] ALU_AND    = 3'b010;
    localparam logic [2:0] ALU_OR     = 3'b011;
    localparam logic [2:0] ALU_XOR    = 3'b100;
    localparam logic [2:0] ALU_NOT    = 3'b101;
    localparam logic [2:0] ALU_PASS_B = 3'b110;

    localparam logic SRC_ALU = 1'b0;
    localparam logic SRC_IMM = 1'b1;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_FETCH2 = 3'd2,
        S_OPND   = 3'd3,
        S_EXEC   = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    // Instructions that carry a second byte (immediate or jump target).
    function automatic logic is_two_byte(input logic [3:0] opcode);
        return (opcode == OP_LDI) || (opcode == OP_JMP) || (opcode == OP_JZ);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: opcode -> ALU/writeback controls and flow flags.
// With CTRL_ILLEGAL_TRAP_EN defined, undefined opcodes B-E decode as halt.
module ctrl_decode
    import proc_defs::*;
(
    input  logic [3:0] opcode,
    output logic [2:0] alu_op,
    output logic       src_sel,
    output logic       writes_reg,
    output logic       two_byte,
    output logic       is_jump,
    output logic       is_halt
);

    always_comb begin
        alu_op     = ALU_ADD;
        src_sel    = SRC_ALU;
        writes_reg = 1'b0;
        is_jump    = 1'b0;
        is_halt    = 1'b0;
        case (opcode)
            OP_MOV: begin alu_op = ALU_PASS_B; writes_reg = 1'b1; end
            OP_ADD: begin alu_op = ALU_ADD;    writes_reg = 1'b1; end
            OP_SUB: begin alu_op = ALU_SUB;    writes_reg = 1'b1; end
            OP_AND: begin alu_op = ALU_AND;    writes_reg = 1'b1; end
            OP_OR:  begin alu_op = ALU_OR;     writes_reg = 1'b1; end
            OP_XOR: begin alu_op = ALU_XOR;    writes_reg = 1'b1; end
            OP_NOT: begin alu_op = ALU_NOT;    writes_reg = 1'b1; end
            OP_LDI: begin src_sel = SRC_IMM;   writes_reg = 1'b1; end
            OP_JMP,
            OP_JZ:   is_jump = 1'b1;
            OP_HALT: is_halt = 1'b1;
`ifdef CTRL_ILLEGAL_TRAP_EN
            4'hB, 4'hC, 4'hD, 4'hE: is_halt = 1'b1;
`endif
            default: ;
        endcase
    end

    assign two_byte = is_two_byte(opcode);

endmodule

// File: rtl/ctrl_sequencer.sv
// Instruction sequencer and control FSM for the 4-bit processor.
// Optional trap on undefined opcodes B-E is enabled by CTRL_ILLEGAL_TRAP_EN (see ctrl_decode).
module ctrl_sequencer
    import proc_defs::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [7:0]        instr,
    input  logic              zero_flag,
    output logic [ADDR_W-1:0] pc,
    output logic              instr_rd,
    output logic [1:0]        rx_sel,
    output logic [1:0]        ry_sel,
    output logic              load_en,
    output logic [2:0]        alu_op,
    output logic              src_sel,
    output logic [DATA_W-1:0] imm,
    output logic              halted
);

    state_t     state;
    state_t     next_state;
    logic [7:0] ir;
    logic [7:0] opnd;

    logic       writes_reg;
    logic       two_byte;
    logic       is_jump;
    logic       is_halt;
    logic       jump_taken;

    ctrl_decode u_decode (
        .opcode     (ir[7:4]),
        .alu_op     (alu_op),
        .src_sel    (src_sel),
        .writes_reg (writes_reg),
        .two_byte   (two_byte),
        .is_jump    (is_jump),
        .is_halt    (is_halt)
    );

    assign rx_sel = ir[3:2];
    assign ry_sel = ir[1:0];
    assign imm    = opnd[DATA_W-1:0];

    // JZ only redirects when the ALU reports zero; JMP always does.
    assign jump_taken = is_jump && ((ir[7:4] != OP_JZ) || zero_flag);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
            pc    <= '0;
            ir    <= '0;
            opnd  <= '0;
        end else begin
            state <= next_state;
            case (state)
                S_DECODE: begin
                    ir <= instr;
                    pc <= pc + ADDR_W'(1);
                end
                S_OPND: begin
                    opnd <= instr;
                    pc   <= pc + ADDR_W'(1);
                end
                S_EXEC: begin
                    if (jump_taken) begin
                        pc <= opnd[ADDR_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    // The DECODE branch looks at the raw ROM byte since ir is loaded on this same edge.
    always_comb begin
        next_state = state;
        instr_rd   = 1'b0;
        load_en    = 1'b0;
        halted     = 1'b0;
        case (state)
            S_FETCH: begin
                instr_rd = run;
                if (run) next_state = S_DECODE;
            end
            S_DECODE: begin
                next_state = is_two_byte(instr[7:4]) ? S_FETCH2 : S_EXEC;
            end
            S_FETCH2: begin
                instr_rd   = 1'b1;
                next_state = S_OPND;
            end
            S_OPND: begin
                next_state = S_EXEC;
            end
            S_EXEC: begin
                if (is_halt)         next_state = S_HALT;
                else if (writes_reg) next_state = S_WB;
                else                 next_state = S_FETCH;
            end
            S_WB: begin
                load_en    = 1'b1;
                next_state = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: next_state = S_FETCH;
        endcase
        if (reset) begin
            instr_rd = 1'b0;
            load_en  = 1'b0;
            halted   = 1'b0;
        end
    end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer: directed programs plus random programs,
// checked against an instruction-level model (latency table and ISA semantics).
module tb_ctrl_sequencer;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              run;
    logic [7:0]        instr;
    logic              zero_flag;
    logic [ADDR_W-1:0] pc;
    logic              instr_rd;
    logic [1:0]        rx_sel;
    logic [1:0]        ry_sel;
    logic              load_en;
    logic [2:0]        alu_op;
    logic              src_sel;
    logic [DATA_W-1:0] imm;
    logic              halted;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] rom [256];
    logic [7:0] model_pc;
    bit         stopped;

    ctrl_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .instr     (instr),
        .zero_flag (zero_flag),
        .pc        (pc),
        .instr_rd  (instr_rd),
        .rx_sel    (rx_sel),
        .ry_sel    (ry_sel),
        .load_en   (load_en),
        .alu_op    (alu_op),
        .src_sel   (src_sel),
        .imm       (imm),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive inputs just after the falling edge; outputs are sampled 1 time unit later.
    task automatic applyStimulus(input logic r, input logic z);
        run       = r;
        zero_flag = z;
        #1;
    endtask

    // Advance one clock, modelling a synchronous ROM read on the rising edge.
    task automatic tick();
        logic       rd;
        logic [7:0] addr;
        rd   = instr_rd;
        addr = pc;
        @(posedge clk);
        #1;
        if (rd === 1'b1) instr = rom[addr];
        @(negedge clk);
    endtask

    task automatic applyReset();
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0);
        checkOutput("rst_instr_rd", instr_rd, 0);
        checkOutput("rst_load_en", load_en, 0);
        checkOutput("rst_halted", halted, 0);
        tick();
        reset    = 1'b0;
        model_pc = 8'h00;
    endtask

    task automatic clearRom();
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    endtask

    function automatic logic [2:0] aluFor(input logic [3:0] op);
        case (op)
            4'h1: return 3'b110;
            4'h2: return 3'b000;
            4'h3: return 3'b001;
            4'h4: return 3'b010;
            4'h5: return 3'b011;
            4'h6: return 3'b100;
            4'h7: return 3'b101;
            default: return 3'b000;
        endcase
    endfunction

    // Execute one instruction at model_pc; zsel 0/1 forces zero_flag, 2 randomises it.
    task automatic runInstr(input int zsel, output bit halt_seen);
        logic [7:0] p, ins, opv, nxt;
        logic [3:0] op;
        logic       z;
        bit         two, wr, hlt;
        int         lat;
        p   = model_pc;
        ins = rom[p];
        op  = ins[7:4];
        opv = rom[8'(p + 8'd1)];
        two = (op == 4'h8) || (op == 4'h9) || (op == 4'hA);
        wr  = (op >= 4'h1) && (op <= 4'h8);
        hlt = (op == 4'hF);
`ifdef CTRL_ILLEGAL_TRAP_EN
        if (op >= 4'hB && op <= 4'hE) hlt = 1'b1;
`endif
        lat = two ? (wr ? 6 : 5) : (wr ? 4 : 3);
        z   = (zsel == 2) ? 1'($urandom_range(1)) : 1'(zsel);

        if ($urandom_range(3) == 0) begin
            repeat ($urandom_range(1, 3)) begin
                applyStimulus(1'b0, z);
                checkOutput("stall_instr_rd", instr_rd, 0);
                checkOutput("stall_pc", pc, p);
                checkOutput("stall_load_en", load_en, 0);
                tick();
            end
        end

        applyStimulus(1'b1, z);
        checkOutput("fetch_pc", pc, p);
        checkOutput("fetch_instr_rd", instr_rd, 1);
        checkOutput("fetch_halted", halted, 0);
        checkOutput("fetch_load_en", load_en, 0);
        tick();

        for (int c = 1; c < lat; c++) begin
            applyStimulus(1'($urandom_range(1)), z);
            checkOutput("load_en", load_en, (wr && c == lat - 1) ? 1 : 0);
            checkOutput("instr_rd", instr_rd, (two && c == 2) ? 1 : 0);
            if (wr && c >= lat - 2) begin
                checkOutput("rx_sel", rx_sel, ins[3:2]);
                checkOutput("ry_sel", ry_sel, ins[1:0]);
                checkOutput("src_sel", src_sel, (op == 4'h8) ? 1 : 0);
                if (op == 4'h8) checkOutput("imm", imm, opv[3:0]);
                else            checkOutput("alu_op", alu_op, aluFor(op));
            end
            tick();
        end

        nxt = two ? 8'(p + 8'd2) : 8'(p + 8'd1);
        if (op == 4'h9 || (op == 4'hA && z)) nxt = opv;
        model_pc = nxt;

        halt_seen = hlt;
        if (hlt) begin
            repeat (2) begin
                applyStimulus(1'($urandom_range(1)), z);
                checkOutput("halt_halted", halted, 1);
                checkOutput("halt_instr_rd", instr_rd, 0);
                checkOutput("halt_load_en", load_en, 0);
                checkOutput("halt_pc", pc, model_pc);
                tick();
            end
        end
    endtask

    task automatic runProgram(input int n, input int zsel);
        bit h;
        h = 1'b0;
        for (int i = 0; i < n && !h; i++) runInstr(zsel, h);
        if (!h) begin
            applyStimulus(1'b0, 1'b0);
            checkOutput("end_pc", pc, model_pc);
            checkOutput("end_instr_rd", instr_rd, 0);
        end
    endtask

    initial begin
        reset     = 1'b1;
        run       = 1'b0;
        zero_flag = 1'b0;
        instr     = 8'h00;
        @(negedge clk);

        $display("[TB] ADD r1,r2");
        clearRom();
        rom[0] = 8'h26;
        applyReset();
        runProgram(1, 2);
        checkOutput("add_pc", pc, 1);

        $display("[TB] LDI r3,5");
        clearRom();
        rom[0] = 8'h8C; rom[1] = 8'h05;
        applyReset();
        runProgram(1, 2);
        checkOutput("ldi_pc", pc, 2);

        $display("[TB] JZ taken / not taken");
        clearRom();
        rom[0] = 8'hA0; rom[1] = 8'h10;
        applyReset();
        runProgram(1, 1);
        checkOutput("jz_taken_pc", pc, 8'h10);
        applyReset();
        runProgram(1, 0);
        checkOutput("jz_fall_pc", pc, 8'h02);

        $display("[TB] HALT then reset");
        clearRom();
        rom[0] = 8'hF0;
        applyReset();
        runProgram(1, 2);
        applyReset();
        applyStimulus(1'b0, 1'b0);
        checkOutput("post_halt_halted", halted, 0);
        checkOutput("post_halt_pc", pc, 0);

        $display("[TB] PC wrap and run hold");
        clearRom();
        rom[0] = 8'h90; rom[1] = 8'hFF; rom[255] = 8'h00;
        applyReset();
        runProgram(2, 2);
        checkOutput("wrap_pc", pc, 8'h00);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0);
            checkOutput("hold_instr_rd", instr_rd, 0);
            checkOutput("hold_pc", pc, 8'h00);
            tick();
        end

        $display("[TB] Reset during WB");
        clearRom();
        rom[0] = 8'h26;
        applyReset();
        repeat (3) begin
            applyStimulus(1'b1, 1'b0);
            tick();
        end
        applyStimulus(1'b1, 1'b0);
        checkOutput("wb_load_en", load_en, 1);
        reset = 1'b1;
        #1;
        checkOutput("wb_rst_load_en", load_en, 0);
        tick();
        reset = 1'b0;
        applyStimulus(1'b1, 1'b0);
        checkOutput("wb_rst_pc", pc, 0);
        checkOutput("wb_rst_instr_rd", instr_rd, 1);
        checkOutput("wb_rst_next_load_en", load_en, 0);
        tick();
        applyReset();

        $display("[TB] Undefined opcode B0");
        clearRom();
        rom[0] = 8'hB0; rom[1] = 8'h00;
        applyReset();
        runProgram(2, 2);

        $display("[TB] Random programs");
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
            applyReset();
            runProgram(25, 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
- Instruction sequencer and control FSM for the 4-bit processor.
- Fetches 8-bit instructions from a synchronous program ROM and decodes them.
- Drives the rx/ry register-select lines and the single write strobe. The strobe feeds the 1-to-4 register-load demultiplexer, which fans it out to one of four registers.
- Also drives the ALU opcode, the writeback source select, the immediate nibble, and the program counter.

Parameters:
- ADDR_W, 8, program counter / ROM address width (legal range 1..8).
- DATA_W, 4, datapath width; width of imm.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- run  input  1  when low, the FSM stalls in FETCH; other states complete normally.
- instr  input  8  ROM read data; valid one cycle after instr_rd is high.
- zero_flag  input  1  ALU zero flag, sampled in EXEC.
- pc  output  ADDR_W  ROM address.
- instr_rd  output  1  ROM read strobe.
- rx_sel  output  2  destination/first operand select (ir[3:2]); drives the demux select.
- ry_sel  output  2  second operand select (ir[1:0]).
- load_en  output  1  register write strobe; drives the demux data input.
- alu_op  output  3  ALU operation.
- src_sel  output  1  writeback source: 0 = ALU, 1 = imm.
- imm  output  DATA_W  immediate, opnd[DATA_W-1:0].
- halted  output  1  high while in HALT.

Behaviour:
- Instruction format: [7:4] opcode, [3:2] rx, [1:0] ry.
- Two-byte ops take a second byte (opnd) as the immediate or the jump target.
- Opcode map:
  - 0 NOP
  - 1 MOV: alu_op PASS_B = 110
  - 2 ADD = 000
  - 3 SUB = 001
  - 4 AND = 010
  - 5 OR = 011
  - 6 XOR = 100
  - 7 NOT = 101
  - 8 LDI (2-byte, src_sel = 1)
  - 9 JMP (2-byte)
  - A JZ (2-byte)
  - F HALT
  - B–E undefined
- Opcodes 1–8 write a register; all others do not.
- Reset values: state FETCH, pc 0, ir 0 (NOP), opnd 0; instr_rd 0, load_en 0, halted 0 during the reset cycle.
- Selects: rx_sel, ry_sel, alu_op and src_sel decode combinationally from ir and hold steady through EXEC and WB.
- FSM states and transitions:
  - FETCH: instr_rd = run. If run = 1, go to DECODE; otherwise stay.
  - DECODE: ir <= instr; pc <= pc+1. Go to FETCH2 if the opcode is 8/9/A; otherwise go to EXEC.
  - FETCH2: instr_rd = 1; go to OPND.
  - OPND: opnd <= instr; pc <= pc+1; go to EXEC.
  - EXEC:
    - JMP: pc <= opnd[ADDR_W-1:0].
    - JZ: same load, only if zero_flag = 1.
    - HALT: go to HALT.
    - Opcodes 1–8: go to WB.
    - Otherwise: go to FETCH.
  - WB: load_en = 1 for exactly one cycle; go to FETCH.
  - HALT: halted = 1; exit only on reset.
- Latency: a 1-byte ALU op takes 4 cycles (FETCH → DECODE → EXEC → WB); LDI takes 6; a 1-byte non-write op takes 3.
- PC increment wraps from 2^ADDR_W−1 to 0.
- JZ/JMP in EXEC override the increment; there is no simultaneous increment in EXEC.
- load_en is never high outside WB.
- Reset asserted in any state (including WB) forces the reset values on the next edge.
- run deasserted outside FETCH has no effect until the FSM returns to FETCH.

Optional Feature:
- Macro CTRL_ILLEGAL_TRAP_EN.
- Defined: opcodes B–E go DECODE → EXEC → HALT; halted rises 2 cycles after DECODE.
- Undefined: opcodes B–E execute as NOP; no write, no PC change beyond the increment.

Decomposition:
- Shared package/header proc_defs holds:
  - opcode constants OP_NOP..OP_HALT
  - ALU_ADD..ALU_PASS_B encodings
  - state encodings S_FETCH..S_HALT
  - SRC_ALU / SRC_IMM
- One natural sub-module: ctrl_decode, a combinational mapping from ir to {alu_op, src_sel, writes_reg, two_byte, is_jump, is_halt}.
- The FSM, pc, ir and opnd registers stay in ctrl_sequencer.

Test Plan:
- Reset then ROM[0] = 8'h26 (ADD r1,r2) → instr_rd at cycle 0; rx_sel = 1, ry_sel = 2, alu_op = 000 in EXEC; load_en single pulse in cycle 3; pc = 1.
- ROM[0..1] = 8'h8C, 8'h05 (LDI r3,5) → src_sel = 1, imm = 5, rx_sel = 3; load_en pulse at cycle 5; pc = 2.
- ROM[0..1] = 8'hA0, 8'h10 (JZ 0x10): with zero_flag = 1 → pc = 0x10 after EXEC; with zero_flag = 0 → pc = 2; load_en never high.
- ROM[0] = 8'hF0 → halted = 1 from cycle 3 onward and no further instr_rd. Then reset pulse → halted = 0, pc = 0.
- With pc = 0xFF and a NOP at 0xFF → pc wraps to 0x00. Holding run = 0 keeps the FSM in FETCH with instr_rd = 0 and pc unchanged.
- Reset asserted during WB → load_en low next cycle; state FETCH, pc 0. Opcode 8'hB0 → halt with CTRL_ILLEGAL_TRAP_EN, NOP without.
